// File: rtl/rally_score_ctrl_pkg.sv
// Shared game parameters for the rally scoring and ball position controllers:
// player encodings, court geometry, ball spawn points and the scorer state type.
package rally_score_ctrl_pkg;

    localparam logic PLAYER1 = 1'b0;
    localparam logic PLAYER2 = 1'b1;

    localparam int GAME_NET_X          = 512;
    localparam int GAME_BALL_SIZE      = 64;
    localparam int GAME_START_POSX_PL1 = 250;
    localparam int GAME_START_POSX_PL2 = 774;
    localparam int GAME_START_POSY     = 555;

    typedef enum logic [1:0] {
        SERVE,
        RALLY,
        POINT,
        GAME_OVER
    } rally_state_t;

    function automatic logic [4:0] sat_inc5(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

endpackage

// File: rtl/rally_score_ctrl_edge_det.sv
// Single-bit rising-edge detector: one registered stage, pulse while the
// input is high and was low on the previous clock.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk) begin
        if (rst) din_q <= 1'b0;
        else     din_q <= din;
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/rally_score_ctrl.sv
// Rally scorer: counts touches per side, awards points on ground contact or
// touch overflow, and tracks the match until one player wins by two.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   SERVE     | ball hanging at spawn, waiting for the first counted touch
//   RALLY     | ball in play, touches counted, ground / overflow award points
//   POINT     | point awarded, waiting for the ball to respawn at the server
//   GAME_OVER | match decided, only start leaves
module rally_score_ctrl
    import rally_score_ctrl_pkg::*;
#(
    parameter int WIN_SCORE      = 15,
    parameter int MAX_TOUCH      = 3,
    parameter int NET_X          = GAME_NET_X,
    parameter int BALL_SIZE      = GAME_BALL_SIZE,
    parameter int GHOST_CYCLES   = 16_250_000,
    parameter int START_POSX_PL1 = GAME_START_POSX_PL1,
    parameter int START_POSX_PL2 = GAME_START_POSX_PL2,
    parameter int START_POSY     = GAME_START_POSY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pl1_col,
    input  logic        pl2_col,
    input  logic        gnd_col,
    input  logic [11:0] ball_posx,
    input  logic [11:0] ball_posy,
    output logic        last_touch,
    output logic        ovr_touch,
    output logic [4:0]  pl1_score,
    output logic [4:0]  pl2_score,
    output logic [2:0]  pl1_touches,
    output logic [2:0]  pl2_touches,
    output logic        point,
    output logic        game_over,
    output logic        winner
);

    localparam logic [4:0]  WIN_V       = 5'(WIN_SCORE);
    localparam logic [2:0]  TOUCH_LIMIT = 3'(MAX_TOUCH + 1);
    localparam logic [12:0] NET_X_V     = 13'(NET_X);
    localparam logic [12:0] HALF_BALL_V = 13'(BALL_SIZE / 2);
    localparam logic [23:0] GHOST_V     = 24'(GHOST_CYCLES);
    localparam logic [11:0] START_X1_V  = 12'(START_POSX_PL1);
    localparam logic [11:0] START_X2_V  = 12'(START_POSX_PL2);
    localparam logic [11:0] START_Y_V   = 12'(START_POSY);

    logic pl1_edge, pl2_edge, gnd_edge;

    edge_det u_pl1_edge (.clk(clk), .rst(rst), .din(pl1_col), .rise(pl1_edge));
    edge_det u_pl2_edge (.clk(clk), .rst(rst), .din(pl2_col), .rise(pl2_edge));
    edge_det u_gnd_edge (.clk(clk), .rst(rst), .din(gnd_col), .rise(gnd_edge));

    rally_state_t state, state_n;
    logic        toucher, toucher_n;
    logic [23:0] ghost_cnt, ghost_n;
    logic        last_n, ovr_n, point_n, go_n, winner_n;
    logic [4:0]  p1s_n, p2s_n;
    logic [2:0]  p1t_n, p2t_n;

    logic        touch_ok, touch_by, award, award_to, ball_left;
    logic [2:0]  cnt_new;
    logic [4:0]  win_new, lose_score;

    // Ball centre left of the net means it landed on player 1's side.
    assign ball_left = ({1'b0, ball_posx} + HALF_BALL_V) < NET_X_V;

    always_comb begin
        state_n    = state;
        toucher_n  = toucher;
        ghost_n    = (ghost_cnt != 24'd0) ? ghost_cnt - 24'd1 : 24'd0;
        last_n     = last_touch;
        ovr_n      = ovr_touch;
        point_n    = 1'b0;
        go_n       = game_over;
        winner_n   = winner;
        p1s_n      = pl1_score;
        p2s_n      = pl2_score;
        p1t_n      = pl1_touches;
        p2t_n      = pl2_touches;
        touch_ok   = 1'b0;
        touch_by   = PLAYER1;
        award      = 1'b0;
        award_to   = PLAYER1;
        cnt_new    = 3'd0;
        win_new    = 5'd0;
        lose_score = 5'd0;

        // Player 1 has priority; a same-player re-touch inside the ghost window is a bounce artefact.
        if (pl1_edge) begin
            touch_ok = !(toucher == PLAYER1 && ghost_cnt != 24'd0);
            touch_by = PLAYER1;
        end else if (pl2_edge) begin
            touch_ok = !(toucher == PLAYER2 && ghost_cnt != 24'd0);
            touch_by = PLAYER2;
        end

        case (state)
            SERVE, RALLY: begin
                if (touch_ok) begin
                    cnt_new   = ((touch_by == PLAYER1) ? pl1_touches : pl2_touches) + 3'd1;
                    p1t_n     = (touch_by == PLAYER1) ? cnt_new : 3'd0;
                    p2t_n     = (touch_by == PLAYER2) ? cnt_new : 3'd0;
                    ghost_n   = GHOST_V;
                    toucher_n = touch_by;
                    if (state == SERVE) state_n = RALLY;
                end
                if (state == RALLY) begin
                    if (gnd_edge) begin
                        award    = 1'b1;
                        award_to = ball_left ? PLAYER2 : PLAYER1;
                    end else if (touch_ok && cnt_new == TOUCH_LIMIT) begin
                        award    = 1'b1;
                        award_to = ~touch_by;
                        ovr_n    = 1'b1;
                    end
                end
            end
            POINT: begin
                if (!gnd_col && ball_posy == START_Y_V &&
                    ball_posx == ((last_touch == PLAYER2) ? START_X2_V : START_X1_V)) begin
                    p1t_n   = 3'd0;
                    p2t_n   = 3'd0;
                    ovr_n   = 1'b0;
                    state_n = SERVE;
                end
            end
            GAME_OVER: begin
                if (start) begin
                    p1s_n   = 5'd0;
                    p2s_n   = 5'd0;
                    p1t_n   = 3'd0;
                    p2t_n   = 3'd0;
                    ovr_n   = 1'b0;
                    go_n    = 1'b0;
                    last_n  = PLAYER1;
                    state_n = SERVE;
                end
            end
            default: state_n = SERVE;
        endcase

        if (award) begin
            point_n = 1'b1;
            last_n  = award_to;
            if (award_to == PLAYER1) begin
                p1s_n      = sat_inc5(pl1_score);
                win_new    = p1s_n;
                lose_score = pl2_score;
            end else begin
                p2s_n      = sat_inc5(pl2_score);
                win_new    = p2s_n;
                lose_score = pl1_score;
            end
            if (win_new >= WIN_V && {1'b0, win_new} >= ({1'b0, lose_score} + 6'd2)) begin
                state_n  = GAME_OVER;
                go_n     = 1'b1;
                winner_n = award_to;
            end else begin
                state_n = POINT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SERVE;
            toucher     <= PLAYER1;
            ghost_cnt   <= 24'd0;
            last_touch  <= PLAYER1;
            ovr_touch   <= 1'b0;
            point       <= 1'b0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
            pl1_score   <= 5'd0;
            pl2_score   <= 5'd0;
            pl1_touches <= 3'd0;
            pl2_touches <= 3'd0;
        end else begin
            state       <= state_n;
            toucher     <= toucher_n;
            ghost_cnt   <= ghost_n;
            last_touch  <= last_n;
            ovr_touch   <= ovr_n;
            point       <= point_n;
            game_over   <= go_n;
            winner      <= winner_n;
            pl1_score   <= p1s_n;
            pl2_score   <= p2s_n;
            pl1_touches <= p1t_n;
            pl2_touches <= p2t_n;
        end
    end

endmodule

// File: tb/tb_rally_score_ctrl.sv
// Directed bench for rally_score_ctrl with a shortened ghost window so
// hold-off behaviour can be exercised in a few hundred cycles.
module tb_rally_score_ctrl;

    localparam int GH = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pl1_col = 1'b0, pl2_col = 1'b0, gnd_col = 1'b0;
    logic [11:0] ball_posx = 12'd600, ball_posy = 12'd100;
    logic        last_touch, ovr_touch, point, game_over, winner;
    logic [4:0]  pl1_score, pl2_score;
    logic [2:0]  pl1_touches, pl2_touches;

    int n_checks = 0;
    int n_bad = 0;
    int exp1 = 0, exp2 = 0;
    logic tb_last = 1'b0;

    rally_score_ctrl #(.GHOST_CYCLES(GH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .pl1_col(pl1_col), .pl2_col(pl2_col), .gnd_col(gnd_col),
        .ball_posx(ball_posx), .ball_posy(ball_posy),
        .last_touch(last_touch), .ovr_touch(ovr_touch),
        .pl1_score(pl1_score), .pl2_score(pl2_score),
        .pl1_touches(pl1_touches), .pl2_touches(pl2_touches),
        .point(point), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One low cycle, then the requested collisions high for exactly one cycle.
    task automatic touch(input logic a, input logic b, input logic g);
        pl1_col = 1'b0; pl2_col = 1'b0; gnd_col = 1'b0;
        tick(1);
        pl1_col = a; pl2_col = b; gnd_col = g;
        tick(1);
        pl1_col = 1'b0; pl2_col = 1'b0; gnd_col = 1'b0;
    endtask

    task automatic return_to_serve(input logic side);
        ball_posx = side ? 12'd774 : 12'd250;
        ball_posy = 12'd555;
        tick(2);
        ball_posx = 12'd600;
        ball_posy = 12'd100;
        n_checks++;
        if (pl1_touches !== 3'd0 || pl2_touches !== 3'd0 || ovr_touch !== 1'b0) begin
            n_bad++;
            $display("FAIL serve_clear: got t1=%0d t2=%0d ovr=%b want 0 0 0", pl1_touches, pl2_touches, ovr_touch);
        end
    endtask

    // Serve touch by the player who did not touch last, then ground at posx.
    task automatic score_point(input logic who, input logic [11:0] posx);
        logic x;
        logic exp_go;
        x = ~tb_last;
        touch(x == 1'b0, x == 1'b1, 1'b0);
        tb_last = x;
        ball_posx = posx;
        touch(1'b0, 1'b0, 1'b1);
        if (who == 1'b0) exp1++; else exp2++;
        exp_go = who ? (exp2 >= 15 && exp2 >= exp1 + 2) : (exp1 >= 15 && exp1 >= exp2 + 2);
        n_checks++;
        if (pl1_score !== 5'(exp1) || pl2_score !== 5'(exp2)) begin
            n_bad++;
            $display("FAIL score_%0d_%0d: got %0d:%0d want %0d:%0d", exp1, exp2, pl1_score, pl2_score, exp1, exp2);
        end
        n_checks++;
        if (point !== 1'b1 || last_touch !== who || game_over !== exp_go) begin
            n_bad++;
            $display("FAIL award_flags: got point=%b last=%b go=%b want 1 %b %b", point, last_touch, game_over, who, exp_go);
        end
        if (exp_go) begin
            n_checks++;
            if (winner !== who) begin
                n_bad++;
                $display("FAIL winner: got %b want %b", winner, who);
            end
        end
        tick(1);
        n_checks++;
        if (point !== 1'b0) begin
            n_bad++;
            $display("FAIL point_width: got %b want 0", point);
        end
        if (!exp_go) return_to_serve(who);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        n_checks++;
        if ({last_touch, ovr_touch, point, game_over, winner, pl1_score, pl2_score, pl1_touches, pl2_touches} !== 21'd0) begin
            n_bad++;
            $display("FAIL reset: got lt=%b ov=%b pt=%b go=%b w=%b s=%0d:%0d t=%0d:%0d want all 0",
                     last_touch, ovr_touch, point, game_over, winner, pl1_score, pl2_score, pl1_touches, pl2_touches);
        end
        rst = 1'b0;
        tb_last = 1'b0;
        exp1 = 0; exp2 = 0;
        tick(1);
    endtask

    task automatic test_basic_rally;
        touch(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (pl1_touches !== 3'd1) begin n_bad++; $display("FAIL serve_touch: got %0d want 1", pl1_touches); end
        touch(1'b0, 1'b1, 1'b0);
        tb_last = 1'b1;
        n_checks++;
        if (pl1_touches !== 3'd0 || pl2_touches !== 3'd1) begin
            n_bad++;
            $display("FAIL pass_touch: got t1=%0d t2=%0d want 0 1", pl1_touches, pl2_touches);
        end
        ball_posx = 12'd600;
        touch(1'b0, 1'b0, 1'b1);
        exp1 = 1;
        n_checks++;
        if (pl1_score !== 5'd1 || point !== 1'b1 || last_touch !== 1'b0) begin
            n_bad++;
            $display("FAIL ground_right: got s1=%0d pt=%b lt=%b want 1 1 0", pl1_score, point, last_touch);
        end
        tick(1);
        n_checks++;
        if (point !== 1'b0) begin n_bad++; $display("FAIL point_pulse: got %b want 0", point); end
        return_to_serve(1'b0);
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 4; i++) begin
            touch(1'b1, 1'b0, 1'b0);
            if (i < 4) begin
                n_checks++;
                if (pl1_touches !== 3'(i) || ovr_touch !== 1'b0) begin
                    n_bad++;
                    $display("FAIL touch_count_%0d: got %0d ovr=%b want %0d 0", i, pl1_touches, ovr_touch, i);
                end
                tick(GH + 1);
            end
        end
        tb_last = 1'b0;
        exp2 = 1;
        n_checks++;
        if (ovr_touch !== 1'b1 || pl2_score !== 5'd1 || last_touch !== 1'b1 || point !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow: got ovr=%b s2=%0d lt=%b pt=%b want 1 1 1 1", ovr_touch, pl2_score, last_touch, point);
        end
        return_to_serve(1'b1);
    endtask

    task automatic test_ghost;
        tick(GH + 1);
        touch(1'b1, 1'b0, 1'b0);
        tick(98);
        touch(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (pl1_touches !== 3'd1 || pl2_touches !== 3'd0) begin
            n_bad++;
            $display("FAIL ghost_ignore: got t1=%0d t2=%0d want 1 0", pl1_touches, pl2_touches);
        end
        touch(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (pl1_touches !== 3'd0 || pl2_touches !== 3'd1) begin
            n_bad++;
            $display("FAIL ghost_other: got t1=%0d t2=%0d want 0 1", pl1_touches, pl2_touches);
        end
        touch(1'b1, 1'b1, 1'b0);
        tb_last = 1'b0;
        n_checks++;
        if (pl1_touches !== 3'd1 || pl2_touches !== 3'd0) begin
            n_bad++;
            $display("FAIL same_cycle_touch: got t1=%0d t2=%0d want 1 0", pl1_touches, pl2_touches);
        end
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n_checks++;
        if (pl1_score !== 5'd1 || pl2_score !== 5'd1 || pl1_touches !== 3'd1) begin
            n_bad++;
            $display("FAIL start_in_rally: got %0d:%0d t1=%0d want 1:1 1", pl1_score, pl2_score, pl1_touches);
        end
        ball_posx = 12'd100;
        touch(1'b0, 1'b0, 1'b1);
        exp2 = 2;
        n_checks++;
        if (pl2_score !== 5'd2 || last_touch !== 1'b1) begin
            n_bad++;
            $display("FAIL ground_left: got s2=%0d lt=%b want 2 1", pl2_score, last_touch);
        end
        return_to_serve(1'b1);
    endtask

    task automatic test_net_boundary;
        score_point(1'b0, 12'd480);
        score_point(1'b1, 12'd479);
        score_point(1'b0, 12'd4095);
    endtask

    task automatic test_ground_beats_overflow;
        tick(GH + 1);
        for (int i = 1; i <= 3; i++) begin
            touch(1'b0, 1'b1, 1'b0);
            tick(GH + 1);
        end
        n_checks++;
        if (pl2_touches !== 3'd3) begin n_bad++; $display("FAIL pre_overflow: got %0d want 3", pl2_touches); end
        ball_posx = 12'd100;
        touch(1'b0, 1'b1, 1'b1);
        tb_last = 1'b1;
        exp2++;
        n_checks++;
        if (pl2_score !== 5'(exp2) || pl1_score !== 5'(exp1) || ovr_touch !== 1'b0 || last_touch !== 1'b1) begin
            n_bad++;
            $display("FAIL ground_wins: got %0d:%0d ovr=%b lt=%b want %0d:%0d 0 1",
                     pl1_score, pl2_score, ovr_touch, last_touch, exp1, exp2);
        end
        return_to_serve(1'b1);
    endtask

    task automatic test_game_over;
        logic x;
        while (exp1 < 14) score_point(1'b0, 12'd600);
        while (exp2 < 14) score_point(1'b1, 12'd100);
        score_point(1'b0, 12'd600);
        score_point(1'b0, 12'd600);
        ball_posx = 12'd100;
        touch(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (pl1_score !== 5'd16 || pl2_score !== 5'd14 || game_over !== 1'b1 || point !== 1'b0) begin
            n_bad++;
            $display("FAIL over_ignore: got %0d:%0d go=%b pt=%b want 16:14 1 0", pl1_score, pl2_score, game_over, point);
        end
        start = 1'b1;
        tick(1);
        start = 1'b0;
        exp1 = 0; exp2 = 0;
        n_checks++;
        if (pl1_score !== 5'd0 || pl2_score !== 5'd0 || game_over !== 1'b0 || last_touch !== 1'b0 ||
            pl1_touches !== 3'd0 || pl2_touches !== 3'd0 || ovr_touch !== 1'b0) begin
            n_bad++;
            $display("FAIL restart: got %0d:%0d go=%b lt=%b t=%0d:%0d ovr=%b want 0:0 0 0 0:0 0",
                     pl1_score, pl2_score, game_over, last_touch, pl1_touches, pl2_touches, ovr_touch);
        end
        x = ~tb_last;
        touch(x == 1'b0, x == 1'b1, 1'b0);
        tb_last = x;
        n_checks++;
        if ((x ? pl2_touches : pl1_touches) !== 3'd1) begin
            n_bad++;
            $display("FAIL serve_after_restart: got t1=%0d t2=%0d want 1 for player %0d", pl1_touches, pl2_touches, x);
        end
    endtask

    task automatic test_reset_mid_play;
        test_reset;
        touch(1'b0, 1'b1, 1'b0);
        ball_posx = 12'd600;
        touch(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (point !== 1'b1 || pl1_score !== 5'd1) begin
            n_bad++;
            $display("FAIL enter_point: got pt=%b s1=%0d want 1 1", point, pl1_score);
        end
        rst = 1'b1;
        tick(1);
        n_checks++;
        if ({last_touch, ovr_touch, point, game_over, winner, pl1_score, pl2_score, pl1_touches, pl2_touches} !== 21'd0) begin
            n_bad++;
            $display("FAIL reset_in_point: got lt=%b pt=%b s=%0d:%0d t=%0d:%0d want all 0",
                     last_touch, point, pl1_score, pl2_score, pl1_touches, pl2_touches);
        end
        rst = 1'b0;
        touch(1'b0, 1'b1, 1'b0);
        tick(1);
        gnd_col = 1'b1;
        rst = 1'b1;
        tick(1);
        n_checks++;
        if (point !== 1'b0 || pl1_score !== 5'd0 || pl2_score !== 5'd0 || pl2_touches !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_in_rally: got pt=%b s=%0d:%0d t2=%0d want 0 0:0 0", point, pl1_score, pl2_score, pl2_touches);
        end
        rst = 1'b0;
        gnd_col = 1'b0;
        tick(2);
        n_checks++;
        if (point !== 1'b0 || pl1_score !== 5'd0 || pl2_score !== 5'd0) begin
            n_bad++;
            $display("FAIL no_late_point: got pt=%b s=%0d:%0d want 0 0:0", point, pl1_score, pl2_score);
        end
    endtask

    initial begin
        test_reset;
        test_basic_rally;
        test_overflow;
        test_ghost;
        test_net_boundary;
        test_ground_beats_overflow;
        test_game_over;
        test_reset_mid_play;
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
